// File: rtl/par2ser_sched.sv
`default_nettype none
// ============================================================================
//  Module   : par2ser_sched
//  Purpose  : Round-robin scheduler that shares a single par2ser serializer
//             among N requesters. It picks the next valid requester after the
//             previous owner, captures its word, issues one load, paces shift
//             strobes at one per (div+1) cycles and inserts an idle gap.
//  Ports    : clk, reset (async, active high)
//             req_valid/req_data/req_size/req_lsbfirst : packed request lanes
//             req_ready    : one-hot accept strobe (combinational)
//             div, gap     : bit interval and inter-word idle cycles
//             halt         : freezes accept, load, shift and all counters
//             ser_wait     : serializer back-pressure on load
//             ser_load/ser_din/ser_datasize/ser_lsbfirst/ser_shift : to serializer
//             grant        : index of current/last owner
//             active       : scheduler busy (not idle)
//  Revision : 1.0  initial release
// ============================================================================
module par2ser_sched #(
  parameter int N  = 4,
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int CW = $clog2(PW / SW),
  parameter int NW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*PW-1:0] req_data,
  input  logic [N*8-1:0]  req_size,
  input  logic [N-1:0]    req_lsbfirst,
  output logic [N-1:0]    req_ready,
  input  logic [7:0]      div,
  input  logic [3:0]      gap,
  input  logic            halt,
  input  logic            ser_wait,
  output logic            ser_load,
  output logic [PW-1:0]   ser_din,
  output logic [7:0]      ser_datasize,
  output logic            ser_lsbfirst,
  output logic            ser_shift,
  output logic [NW-1:0]   grant,
  output logic            active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t        state;
  logic [NW-1:0] last;
  logic [CW-1:0] beats;
  logic [7:0]    cnt;
  logic [3:0]    gcnt;

  logic [NW-1:0] win;
  logic          found;
  logic          accept;
  logic          shift_fire;
  logic [7:0]    win_size;
  logic [CW-1:0] win_beats;
  int            idx;

  // Round-robin search: start one past the previous owner and take the
  // first valid lane, wrapping modulo N.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req_valid[idx]) begin
        win   = idx[NW-1:0];
        found = 1'b1;
      end
    end
  end

  // Reset is folded in so the combinational ready strobe is also silent
  // while reset is held.
  assign accept     = (state == ST_IDLE) && found && !halt && !reset;
  assign req_ready  = accept ? (N'(1) << win) : '0;
  assign win_size   = req_size[int'(win)*8 +: 8];
  // A size equal to PW/SW wraps to zero here and the word is dropped.
  assign win_beats  = win_size[CW-1:0];

  // Load and shift strobes must react in the same cycle to ser_wait/halt,
  // so they are decoded from the registered state rather than registered.
  assign ser_load   = (state == ST_LOAD) && !halt && !ser_wait;
  assign shift_fire = (state == ST_SHIFT) && (cnt == div) && !halt;
  assign ser_shift  = shift_fire;
  assign active     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      last         <= NW'(N - 1);
      grant        <= '0;
      ser_din      <= '0;
      ser_datasize <= '0;
      ser_lsbfirst <= 1'b0;
      beats        <= '0;
      cnt          <= '0;
      gcnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last         <= win;
            grant        <= win;
            ser_din      <= req_data[int'(win)*PW +: PW];
            ser_datasize <= win_size;
            ser_lsbfirst <= req_lsbfirst[win];
            beats        <= win_beats;
            cnt          <= '0;
            if (win_beats == '0) begin
              if (gap != 4'd0) begin
                state <= ST_GAP;
                gcnt  <= 4'd1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (ser_load) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end

        ST_SHIFT: begin
          if (!halt) begin
            if (cnt == div) begin
              cnt   <= '0;
              beats <= beats - CW'(1);
              if (beats == CW'(1)) begin
                if (gap != 4'd0) begin
                  state <= ST_GAP;
                  gcnt  <= 4'd1;
                end else begin
                  state <= ST_IDLE;
                end
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        ST_GAP: begin
          if (!halt) begin
            // >= guards against gap being lowered while already counting.
            if (gcnt >= gap) begin
              state <= ST_IDLE;
            end else begin
              gcnt <= gcnt + 4'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
